obstacle_engine: RTL

- Parametrised N-channel side-scroller obstacle engine: owns obstacle X positions, frame-tick divider, LFSR respawn with minimum-gap enforcement, speed ramp, AABB collision against the player box, and RUN/OVER game state.
- Feeds the sprite/pixel compositor (positions, animation phase) and the score/HUD logic. Replaces fixed per-obstacle motion logic with a channel-count-generic block.

---
 rtl/obstacle_engine_if.sv | 35 +++
 rtl/obstacle_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/obstacle_engine_if.sv
// Bus between the obstacle engine and its compositor / HUD consumers.
// master = engine side, slave = consumer/driver side.
interface obstacle_engine_if #(
   parameter int NUM_OBS = 4,
   parameter int X_W     = 11,
   parameter int Y_W     = 10
);
   logic                   restart;
   logic                   pause;
   logic [NUM_OBS*Y_W-1:0] obs_y;
   logic [NUM_OBS*8-1:0]   obs_w;
   logic [NUM_OBS*8-1:0]   obs_h;
   logic [X_W-1:0]         pl_x;
   logic [Y_W-1:0]         pl_y;
   logic [7:0]             pl_w;
   logic [7:0]             pl_h;
   logic [NUM_OBS*X_W-1:0] obs_x;
   logic                   game_over;
   logic [3:0]             speed;
   logic [15:0]            score;
   logic [1:0]             anim_phase;
   logic                   tick;

   modport master (
      input  restart, pause, obs_y, obs_w, obs_h,
      input  pl_x, pl_y, pl_w, pl_h,
      output obs_x, game_over, speed, score, anim_phase, tick
   );

   modport slave (
      output restart, pause, obs_y, obs_w, obs_h,
      output pl_x, pl_y, pl_w, pl_h,
      input  obs_x, game_over, speed, score, anim_phase, tick
   );
endinterface

// File: rtl/obstacle_engine.sv
// N-channel side-scroller obstacle engine: motion, respawn, speed ramp, collision.
// Optional macro OBS_ENGINE_PAUSE_EN enables a motion freeze on bus.pause.
module obstacle_engine #(
   parameter int NUM_OBS       = 4,
   parameter int X_W           = 11,
   parameter int Y_W           = 10,
   parameter int SCREEN_W      = 1280,
   parameter int MIN_GAP       = 50,
   parameter int TICK_DIV      = 2000000,
   parameter int SPEED_MAX     = 8,
   parameter int PASS_PER_STEP = 12,
   parameter int INIT_X0       = 1200,
   parameter int INIT_SPACING  = 200
) (
   input logic               clk,
   input logic               reset,
   obstacle_engine_if.master bus
);
   localparam int XS    = X_W + 2;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(PASS_PER_STEP + NUM_OBS);
   localparam int X_MAX = (1 << X_W) - 1;

   typedef enum logic {S_RUN, S_OVER} state_t;

   state_t             r_state;
   logic [X_W-1:0]     r_x [NUM_OBS];
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_speed;
   logic [15:0]        r_score;
   logic [1:0]         r_anim;
   logic               r_tick;
   logic [7:0]         r_lfsr;

   logic [NUM_OBS-1:0] w_hit_v;
   logic [NUM_OBS-1:0] w_resp;
   logic               w_hit;
   logic               w_term;
   logic               w_pause;
   logic               w_step;
   logic [X_W-1:0]     w_nx [NUM_OBS];
   logic [XS-1:0]      w_cand [NUM_OBS];
   logic [XS-1:0]      w_lim;
   logic [3:0]         w_p;
   logic [16:0]        w_sum;
   logic [15:0]        w_score_n;
   logic [CNT_W:0]     w_cnt_n;
   logic [3:0]         w_speed_n;
   logic [7:0]         w_lfsr_n;
   logic [X_W:0]       w_pr;
   logic [Y_W:0]       w_pb;

   function automatic logic [7:0] f_rotl(input logic [7:0] v,
                                         input int n);
      logic [15:0] d;
      d = {v, v} << (n % 8);
      return d[15:8];
   endfunction

`ifdef OBS_ENGINE_PAUSE_EN
   assign w_pause = bus.pause;
`else
   logic w_unused;
   assign w_unused = bus.pause;
   assign w_pause  = 1'b0;
`endif

   assign w_pr = {1'b0, bus.pl_x} + {{(X_W-7){1'b0}}, bus.pl_w};
   assign w_pb = {1'b0, bus.pl_y} + {{(Y_W-7){1'b0}}, bus.pl_h};

   // Open-interval AABB test on widened coordinates so edges never wrap
   for (genvar g = 0; g < NUM_OBS; g++) begin : g_ch
      logic [X_W:0] w_xr;
      logic [Y_W:0] w_yt;
      logic [Y_W:0] w_yb;
      assign w_xr = {1'b0, r_x[g]}
                  + {{(X_W-7){1'b0}}, bus.obs_w[g*8 +: 8]};
      assign w_yt = {1'b0, bus.obs_y[g*Y_W +: Y_W]};
      assign w_yb = w_yt
                  + {{(Y_W-7){1'b0}}, bus.obs_h[g*8 +: 8]};
      assign w_hit_v[g] = ({1'b0, bus.pl_x} < w_xr)
                        && (w_pr > {1'b0, r_x[g]})
                        && ({1'b0, bus.pl_y} < w_yb)
                        && (w_pb > w_yt);
      assign w_resp[g] = r_x[g] <= {{(X_W-4){1'b0}}, r_speed};
   end

   assign w_hit  = |w_hit_v;
   assign w_term = r_div == DIV_W'(TICK_DIV - 1);

   // Respawns resolve in ascending index so later channels see earlier ones
   always_comb begin
      w_lim = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         w_nx[i]   = r_x[i] - {{(X_W-4){1'b0}}, r_speed};
         w_cand[i] = '0;
      end
      for (int i = 0; i < NUM_OBS; i++) begin
         if (w_resp[i]) begin
            w_cand[i] = XS'(SCREEN_W)
                      + XS'({f_rotl(r_lfsr, i), 4'b0000});
            for (int j = 0; j < NUM_OBS; j++) begin
               if (j != i && (!w_resp[j] || j < i)) begin
                  w_lim = {2'b00, (w_resp[j] ? w_nx[j] : r_x[j])}
                        + XS'(bus.obs_w[j*8 +: 8])
                        + XS'(MIN_GAP);
                  if (w_lim > w_cand[i])
                     w_cand[i] = w_lim;
               end
            end
            w_nx[i] = (w_cand[i] > XS'(X_MAX)) ? '1
                                               : w_cand[i][X_W-1:0];
         end
      end
   end

   assign w_p       = 4'($countones(w_resp));
   assign w_sum     = {1'b0, r_score} + 17'(w_p);
   assign w_score_n = w_sum[16] ? 16'hFFFF : w_sum[15:0];
   assign w_cnt_n   = {1'b0, r_cnt} + (CNT_W+1)'(w_p);
   assign w_step    = w_cnt_n >= (CNT_W+1)'(PASS_PER_STEP);
   assign w_speed_n = (r_speed >= 4'(SPEED_MAX)) ? r_speed
                                                 : r_speed + 4'd1;
   assign w_lfsr_n  = {r_lfsr[6:0],
                       r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RUN;
         for (int i = 0; i < NUM_OBS; i++)
            r_x[i] <= X_W'(INIT_X0 + i * INIT_SPACING);
         r_div   <= '0;
         r_cnt   <= '0;
         r_speed <= 4'd1;
         r_score <= '0;
         r_anim  <= '0;
         r_tick  <= 1'b0;
         r_lfsr  <= 8'hA5;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_hit) begin
                  r_state <= S_OVER;
               end else if (!w_pause) begin
                  if (w_term) begin
                     r_div  <= '0;
                     r_tick <= 1'b1;
                     for (int i = 0; i < NUM_OBS; i++)
                        r_x[i] <= w_nx[i];
                     r_lfsr  <= w_lfsr_n;
                     r_anim  <= r_anim + 2'd1;
                     r_score <= w_score_n;
                     if (w_step) begin
                        r_cnt   <= '0;
                        r_speed <= w_speed_n;
                     end else begin
                        r_cnt <= w_cnt_n[CNT_W-1:0];
                     end
                  end else begin
                     r_div <= r_div + 1'b1;
                  end
               end
            end
            S_OVER: begin
               // Score and LFSR survive a restart
               if (bus.restart) begin
                  r_state <= S_RUN;
                  for (int i = 0; i < NUM_OBS; i++)
                     r_x[i] <= X_W'(INIT_X0 + i * INIT_SPACING);
                  r_div   <= '0;
                  r_cnt   <= '0;
                  r_speed <= 4'd1;
                  r_anim  <= '0;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   always_comb begin
      bus.obs_x = '0;
      for (int i = 0; i < NUM_OBS; i++)
         bus.obs_x[i*X_W +: X_W] = r_x[i];
   end

   assign bus.game_over  = (r_state == S_OVER);
   assign bus.speed      = r_speed;
   assign bus.score      = r_score;
   assign bus.anim_phase = r_anim;
   assign bus.tick       = r_tick;
endmodule
